gpr_wb_ctrl: RTL and testbench

Writeback controller that drives the write port of reg_file (wr_data_en, rd, wr_data) and forwards pending results back to the operand-read side. It arbitrates between the single-cycle ALU result and load returns from the LSU. Load returns are buffered in a small queue with a valid/ready handshake. It suppresses x0 writes and provides rs1/rs2 bypass data for results not yet visible in the register array.

---
 rtl/gpr_pkg.sv | 16 +
 rtl/gpr_wb_ld_fifo.sv | 108 ++++++++++
 rtl/gpr_wb_ctrl.sv | 157 +++++++++++++++
 tb/tb_gpr_wb_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared writeback types and default widths for the GPR writeback controller.
package gpr_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int LD_BUF_DEPTH   = 2;

  localparam logic [GPR_ADDR_WIDTH-1:0] GPR_X0 = '0;

  typedef struct packed {
    logic                      valid;
    logic [GPR_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_wb_ld_fifo.sv
// Circular load-return queue with rd-match squash and youngest-entry lookup; 1-cycle push-to-head.
// Caller must not push when full; squashed entries keep their slot until popped.
module gpr_wb_ld_fifo import gpr_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int LD_BUF_DEPTH   = 2,
  localparam int PTR_W         = $clog2(LD_BUF_DEPTH),
  localparam int CNT_W         = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [GPR_ADDR_WIDTH-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  input  logic                      squash_en,
  input  logic [GPR_ADDR_WIDTH-1:0] squash_rd,
  output logic                      head_vld,
  output logic [GPR_ADDR_WIDTH-1:0] head_rd,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [CNT_W-1:0]          count,
  input  logic [GPR_ADDR_WIDTH-1:0] rs1,
  input  logic [GPR_ADDR_WIDTH-1:0] rs2,
  output logic                      q_rs1_hit,
  output logic [DATA_WIDTH-1:0]     q_rs1_data,
  output logic                      q_rs2_hit,
  output logic [DATA_WIDTH-1:0]     q_rs2_data
);

  logic [LD_BUF_DEPTH-1:0]   ent_vld;
  logic [GPR_ADDR_WIDTH-1:0] ent_rd   [LD_BUF_DEPTH];
  logic [DATA_WIDTH-1:0]     ent_data [LD_BUF_DEPTH];
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;

  assign head_vld  = ent_vld[rd_ptr];
  assign head_rd   = ent_rd[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int i = 0; i < LD_BUF_DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      // Squash only touches entries already queued; a same-cycle push is younger.
      for (int i = 0; i < LD_BUF_DEPTH; i++) begin
        if (squash_en && ent_vld[i] && (ent_rd[i] == squash_rd)) ent_vld[i] <= 1'b0;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_vld[wr_ptr]  <= 1'b1;
        ent_rd[wr_ptr]   <= push_rd;
        ent_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef GPR_WB_FWD_EN
  logic [LD_BUF_DEPTH-1:0] rs1_match;
  logic [LD_BUF_DEPTH-1:0] rs2_match;

  always_comb begin
    rs1_match = '0;
    rs2_match = '0;
    for (int i = 0; i < LD_BUF_DEPTH; i++) begin
      rs1_match[i] = ent_vld[i] && (ent_rd[i] == rs1);
      rs2_match[i] = ent_vld[i] && (ent_rd[i] == rs2);
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    q_rs1_hit  = 1'b0;
    q_rs1_data = '0;
    q_rs2_hit  = 1'b0;
    q_rs2_data = '0;
    for (int k = 0; k < LD_BUF_DEPTH; k++) begin
      if (rs1_match[rd_ptr + PTR_W'(k)]) begin
        q_rs1_hit  = 1'b1;
        q_rs1_data = ent_data[rd_ptr + PTR_W'(k)];
      end
      if (rs2_match[rd_ptr + PTR_W'(k)]) begin
        q_rs2_hit  = 1'b1;
        q_rs2_data = ent_data[rd_ptr + PTR_W'(k)];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{rs1, rs2};
  assign q_rs1_hit  = 1'b0;
  assign q_rs1_data = '0;
  assign q_rs2_hit  = 1'b0;
  assign q_rs2_data = '0;
`endif

endmodule

// File: rtl/gpr_wb_ctrl.sv
// Register-file writeback arbiter (ALU over queued loads), 1-cycle registered write stage; only loads see backpressure via ld_ready.
// GPR_WB_FWD_EN enables rs1/rs2 forwarding from the queue and write stage; otherwise forwarding outputs are tied to 0.
module gpr_wb_ctrl import gpr_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int LD_BUF_DEPTH   = 2,
  localparam int CNT_W         = $clog2(LD_BUF_DEPTH) + 1
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  input  logic                      alu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      wr_data_en,
  output logic [GPR_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [GPR_ADDR_WIDTH-1:0] rs1,
  input  logic [GPR_ADDR_WIDTH-1:0] rs2,
  output logic                      fwd_rs1_hit,
  output logic [DATA_WIDTH-1:0]     fwd_rs1_data,
  output logic                      fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0]     fwd_rs2_data,
  output logic [CNT_W-1:0]          ld_buf_count
);

  logic                      alu_sel;
  logic                      ld_keep;
  logic                      q_empty;
  logic                      q_full;
  logic                      q_pop;
  logic                      q_push;
  logic                      ld_bypass;
  logic                      head_vld;
  logic [GPR_ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]     head_data;
  logic                      q_rs1_hit;
  logic [DATA_WIDTH-1:0]     q_rs1_data;
  logic                      q_rs2_hit;
  logic [DATA_WIDTH-1:0]     q_rs2_data;
  logic                      nxt_en;
  logic [GPR_ADDR_WIDTH-1:0] nxt_rd;
  logic [DATA_WIDTH-1:0]     nxt_data;

  assign q_empty  = (ld_buf_count == '0);
  assign q_full   = (ld_buf_count == CNT_W'(LD_BUF_DEPTH));
  assign ld_ready = !q_full && wb_rst_n;

  assign alu_sel   = alu_valid && (alu_rd != GPR_X0);
  assign ld_keep   = ld_valid && ld_ready && (ld_rd != GPR_X0);
  assign q_pop     = !alu_sel && !q_empty;
  assign ld_bypass = ld_keep && !alu_sel && q_empty;
  assign q_push    = ld_keep && !ld_bypass;

  gpr_wb_ld_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
    .LD_BUF_DEPTH   (LD_BUF_DEPTH)
  ) u_ld_fifo (
    .clk        (wb_clk),
    .rst_n      (wb_rst_n),
    .push       (q_push),
    .push_rd    (ld_rd),
    .push_data  (ld_data),
    .pop        (q_pop),
    .squash_en  (alu_sel),
    .squash_rd  (alu_rd),
    .head_vld   (head_vld),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (ld_buf_count),
    .rs1        (rs1),
    .rs2        (rs2),
    .q_rs1_hit  (q_rs1_hit),
    .q_rs1_data (q_rs1_data),
    .q_rs2_hit  (q_rs2_hit),
    .q_rs2_data (q_rs2_data)
  );

  // A popped squashed entry burns the drain slot without writing.
  always_comb begin
    nxt_en   = 1'b0;
    nxt_rd   = '0;
    nxt_data = '0;
    if (alu_sel) begin
      nxt_en   = 1'b1;
      nxt_rd   = alu_rd;
      nxt_data = alu_data;
    end else if (q_pop) begin
      if (head_vld) begin
        nxt_en   = 1'b1;
        nxt_rd   = head_rd;
        nxt_data = head_data;
      end
    end else if (ld_bypass) begin
      nxt_en   = 1'b1;
      nxt_rd   = ld_rd;
      nxt_data = ld_data;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_data_en <= 1'b0;
      rd         <= '0;
      wr_data    <= '0;
    end else begin
      wr_data_en <= nxt_en;
      rd         <= nxt_rd;
      wr_data    <= nxt_data;
    end
  end

`ifdef GPR_WB_FWD_EN
  logic wb_rs1_hit;
  logic wb_rs2_hit;

  assign wb_rs1_hit = wr_data_en && (rd == rs1);
  assign wb_rs2_hit = wr_data_en && (rd == rs2);

  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    if (rs1 != GPR_X0) begin
      if (q_rs1_hit) begin
        fwd_rs1_hit  = 1'b1;
        fwd_rs1_data = q_rs1_data;
      end else if (wb_rs1_hit) begin
        fwd_rs1_hit  = 1'b1;
        fwd_rs1_data = wr_data;
      end
    end
    if (rs2 != GPR_X0) begin
      if (q_rs2_hit) begin
        fwd_rs2_hit  = 1'b1;
        fwd_rs2_data = q_rs2_data;
      end else if (wb_rs2_hit) begin
        fwd_rs2_hit  = 1'b1;
        fwd_rs2_data = wr_data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{q_rs1_hit, q_rs1_data, q_rs2_hit, q_rs2_data};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs2_data = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed table-driven bench for gpr_wb_ctrl plus hand sequences for forwarding and mid-cycle reset.
module tb_gpr_wb_ctrl;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wr_data_en;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd_rs1_hit;
  logic [31:0] fwd_rs1_data;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs2_data;
  logic [1:0]  ld_buf_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 wb_clk = ~wb_clk;

  gpr_wb_ctrl dut (
    .wb_clk       (wb_clk),
    .wb_rst_n     (wb_rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .wr_data_en   (wr_data_en),
    .rd           (rd),
    .wr_data      (wr_data),
    .rs1          (rs1),
    .rs2          (rs2),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs2_data (fwd_rs2_data),
    .ld_buf_count (ld_buf_count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_rdy;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_data   = ldat;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [4:0] r,
                        input logic [31:0] d, input logic [1:0] c);
    chk({tag, "_en"},  32'(wr_data_en),   32'(en));
    chk({tag, "_rd"},  32'(rd),           32'(r));
    chk({tag, "_dat"}, wr_data,           d);
    chk({tag, "_cnt"}, 32'(ld_buf_count), 32'(c));
  endtask

  task automatic chk_fwd(input string tag, input logic h1, input logic [31:0] d1,
                         input logic h2, input logic [31:0] d2);
    chk({tag, "_h1"}, 32'(fwd_rs1_hit), 32'(h1));
    chk({tag, "_d1"}, fwd_rs1_data,     d1);
    chk({tag, "_h2"}, 32'(fwd_rs2_hit), 32'(h2));
    chk({tag, "_d2"}, fwd_rs2_data,     d2);
  endtask

  initial begin
    //          av    ard    adat          lv    lrd     ldat         rdy   en    erd    edat          cnt
    vt[0]  = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  32'h0,       1'b1, 1'b1, 5'd5,  32'h1234,     2'd0};
    vt[1]  = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 5'd0,  32'h0,        2'd0};
    vt[2]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd4,  32'hB,       1'b1, 1'b1, 5'd3,  32'hA,        2'd1};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 1'b1, 5'd4,  32'hB,        2'd0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'hC,       1'b1, 1'b1, 5'd6,  32'hC,        2'd0};
    vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hD,       1'b1, 1'b0, 5'd0,  32'h0,        2'd0};
    vt[6]  = '{1'b1, 5'd0,  32'h99,       1'b1, 5'd8,  32'hE,       1'b1, 1'b1, 5'd8,  32'hE,        2'd0};
    vt[7]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd10, 32'h21,      1'b1, 1'b1, 5'd1,  32'h11,       2'd1};
    vt[8]  = '{1'b1, 5'd2,  32'h12,       1'b1, 5'd11, 32'h22,      1'b1, 1'b1, 5'd2,  32'h12,       2'd2};
    vt[9]  = '{1'b1, 5'd1,  32'h13,       1'b1, 5'd12, 32'h23,      1'b0, 1'b1, 5'd1,  32'h13,       2'd2};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h23,      1'b0, 1'b1, 5'd10, 32'h21,       2'd1};
    vt[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h23,      1'b1, 1'b1, 5'd11, 32'h22,       2'd1};
    vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 1'b1, 5'd12, 32'h23,       2'd0};
    vt[13] = '{1'b1, 5'd1,  32'h31,       1'b1, 5'd7,  32'h1,       1'b1, 1'b1, 5'd1,  32'h31,       2'd1};
    vt[14] = '{1'b1, 5'd7,  32'h2,        1'b0, 5'd0,  32'h0,       1'b1, 1'b1, 5'd7,  32'h2,        2'd1};
    vt[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 5'd0,  32'h0,        2'd0};
    vt[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 1'b0, 5'd0,  32'h0,        2'd0};

    wb_rst_n = 1'b0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    chk_wb("reset", 1'b0, 5'd0, 32'h0, 2'd0);
    chk("reset_rdy", 32'(ld_ready), 32'd0);
    wb_rst_n = 1'b1;
    #1;
    chk("release_rdy", 32'(ld_ready), 32'd1);
    step();

    // ALU-only, x0, collision, bypass, backpressure drain and squash
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].adat, vt[i].lv, vt[i].lrd, vt[i].ldat);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(ld_ready), 32'(vt[i].e_rdy));
      step();
      chk_wb($sformatf("v%0d", i), vt[i].e_en, vt[i].e_rd, vt[i].e_dat, vt[i].e_cnt);
    end

    // Same-cycle ALU x9 and load x9: the load is younger and must stay queued
    drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 32'h66);
    step();
    chk_wb("fwd_setup", 1'b1, 5'd9, 32'h55, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rs1 = 5'd9;
    rs2 = 5'd0;
    #1;
`ifdef GPR_WB_FWD_EN
    chk_fwd("fwd_q", 1'b1, 32'h66, 1'b0, 32'h0);
`else
    chk_fwd("fwd_q", 1'b0, 32'h0, 1'b0, 32'h0);
`endif
    rs2 = 5'd5;
    #1;
    chk("fwd_miss_h2", 32'(fwd_rs2_hit), 32'd0);
    step();
    chk_wb("fwd_drain", 1'b1, 5'd9, 32'h66, 2'd0);
    rs2 = 5'd9;
    #1;
`ifdef GPR_WB_FWD_EN
    chk_fwd("fwd_wb", 1'b1, 32'h66, 1'b1, 32'h66);
`else
    chk_fwd("fwd_wb", 1'b0, 32'h0, 1'b0, 32'h0);
`endif
    rs1 = 5'd0;
    rs2 = 5'd0;

    // Fill the queue, then reset asynchronously mid-cycle
    drive(1'b1, 5'd1, 32'h41, 1'b1, 5'd13, 32'h51);
    step();
    drive(1'b1, 5'd2, 32'h42, 1'b1, 5'd14, 32'h52);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'h53);
    #1;
    chk("full_cnt", 32'(ld_buf_count), 32'd2);
    chk("full_rdy", 32'(ld_ready), 32'd0);
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk_wb("arst", 1'b0, 5'd0, 32'h0, 2'd0);
    chk("arst_rdy", 32'(ld_ready), 32'd0);
    step();
    chk_wb("arst_hold", 1'b0, 5'd0, 32'h0, 2'd0);
    ld_valid = 1'b0;
    wb_rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(ld_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_wb($sformatf("post_rst%0d", c), 1'b0, 5'd0, 32'h0, 2'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
